// File: rtl/conv_line_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// conv_line_sched
//   Drives req/stall/end of the data-request unit so that K kernel lines of
//   line_words input reads each are issued per convolution window pass.
// Revision: 1.0  initial release
// ----------------------------------------------------------------------------
module conv_line_sched #(
  parameter int REG_WIDTH         = 32,
  parameter int KERNEL_SIZE_WIDTH = 2,
  parameter int CNT_WIDTH         = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic                 i_fifo_afull,
  input  logic [REG_WIDTH-1:0] i_conf_inputshape,
  input  logic [REG_WIDTH-1:0] i_conf_kernelshape,
  output logic                 o_req,
  output logic                 o_stall,
  output logic                 o_end,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [CNT_WIDTH-1:0] o_rd_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_END  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0]                   in_width;
  logic [9:0]                   width_x3;
  logic [7:0]                   line_words_cfg;
  logic [KERNEL_SIZE_WIDTH-1:0] k_cfg;
  logic                         cfg_bad;

  logic [7:0]                   line_words;
  logic [KERNEL_SIZE_WIDTH-1:0] k_lat;
  logic [CNT_WIDTH-1:0]         word_cnt;
  logic [KERNEL_SIZE_WIDTH-1:0] line_cnt;
  logic [CNT_WIDTH-1:0]         rd_cnt;

  logic start_ok;
  logic abort_act;
  logic accept;
  logic word_last;
  logic line_last;
  logic unused_cfg_bits;

  // 3*W formed as W + 2W in 10 bits so the >>2 never loses a carry.
  assign in_width       = i_conf_inputshape[7:0];
  assign width_x3       = {2'b00, in_width} + {1'b0, in_width, 1'b0};
  assign line_words_cfg = width_x3[9:2];
  assign k_cfg          = i_conf_kernelshape[KERNEL_SIZE_WIDTH-1:0];
  assign cfg_bad        = (line_words_cfg == 8'd0) || (k_cfg == '0);

  assign unused_cfg_bits = ^{i_conf_inputshape[REG_WIDTH-1:8],
                             i_conf_kernelshape[REG_WIDTH-1:KERNEL_SIZE_WIDTH]};

  assign start_ok  = (state == S_IDLE) && i_start && !i_abort;
  assign abort_act = (state != S_IDLE) && i_abort;
  // An aborting cycle issues no request, so it can never count as a read.
  assign accept    = (state == S_RUN) && !i_abort && !i_fifo_afull;
  assign word_last = (word_cnt == (CNT_WIDTH'(line_words) - CNT_WIDTH'(1)));
  assign line_last = (line_cnt == (k_lat - KERNEL_SIZE_WIDTH'(1)));

  assign o_stall  = i_fifo_afull;
  assign o_busy   = (state != S_IDLE);
  assign o_rd_cnt = rd_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    o_req     = 1'b0;
    o_end     = 1'b0;
    o_done    = 1'b0;
    o_err     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        state_nxt = cfg_bad ? S_ERR : S_RUN;
      end
      S_RUN: begin
        o_req = 1'b1;
        if (accept && word_last) begin
          state_nxt = S_END;
        end
      end
      S_END: begin
        o_end     = 1'b1;
        state_nxt = line_last ? S_DONE : S_RUN;
      end
      S_DONE: begin
        o_done    = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        o_err     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    // Abort overrides every transition and silences the strobes immediately.
    if (abort_act) begin
      state_nxt = S_IDLE;
      o_req     = 1'b0;
      o_end     = 1'b0;
      o_done    = 1'b0;
      o_err     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_words <= 8'd0;
      k_lat      <= '0;
    end else if (state == S_LOAD) begin
      line_words <= line_words_cfg;
      k_lat      <= k_cfg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt <= '0;
      line_cnt <= '0;
      rd_cnt   <= '0;
    end else if (start_ok) begin
      word_cnt <= '0;
      line_cnt <= '0;
      rd_cnt   <= '0;
    end else begin
      if (accept) begin
        rd_cnt   <= rd_cnt + CNT_WIDTH'(1);
        word_cnt <= word_last ? '0 : (word_cnt + CNT_WIDTH'(1));
      end
      if ((state == S_END) && !i_abort && !line_last) begin
        line_cnt <= line_cnt + KERNEL_SIZE_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_line_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_conv_line_sched
//   Directed timing scenarios plus randomized traffic against a count-down
//   reference model of the window pass.
// Revision: 1.0  initial release
// ----------------------------------------------------------------------------
module tb_conv_line_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        fifo_afull;
  logic [31:0] conf_inshape;
  logic [31:0] conf_kshape;
  logic        req;
  logic        stall;
  logic        line_end;
  logic        busy;
  logic        done;
  logic        err;
  logic [9:0]  rd_cnt;

  int vectors     = 0;
  int miscompares = 0;

  conv_line_sched #(
    .REG_WIDTH        (32),
    .KERNEL_SIZE_WIDTH(2),
    .CNT_WIDTH        (10)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_start           (start),
    .i_abort           (abort),
    .i_fifo_afull      (fifo_afull),
    .i_conf_inputshape (conf_inshape),
    .i_conf_kernelshape(conf_kshape),
    .o_req             (req),
    .o_stall           (stall),
    .o_end             (line_end),
    .o_busy            (busy),
    .o_done            (done),
    .o_err             (err),
    .o_rd_cnt          (rd_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mask(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Reference model: reads still owed in the current line, lines still owed,
  // and one-cycle flags for the load, end-of-line, done and error cycles.
  bit model_valid = 1'b0;
  bit m_load, m_end, m_done, m_err;
  int m_lw, m_wl, m_ll, m_rd;

  initial begin
    m_load = 0; m_end = 0; m_done = 0; m_err = 0;
    m_lw = 0; m_wl = 0; m_ll = 0; m_rd = 0;
  end

  always @(posedge clk) begin
    int lw_n, wl_n, ll_n, rd_n, kk;
    bit load_n, end_n, done_n, err_n, mbusy;
    lw_n = m_lw; wl_n = m_wl; ll_n = m_ll; rd_n = m_rd;
    load_n = m_load; end_n = m_end; done_n = m_done; err_n = m_err;
    mbusy = m_load || (m_wl > 0) || m_end || m_done || m_err;
    if (rst) begin
      load_n = 0; end_n = 0; done_n = 0; err_n = 0;
      wl_n = 0; ll_n = 0; rd_n = 0;
    end else if (!model_valid) begin
      rd_n = m_rd;
    end else if (mbusy && abort) begin
      load_n = 0; end_n = 0; done_n = 0; err_n = 0; wl_n = 0; ll_n = 0;
    end else if (!mbusy) begin
      if (start && !abort) begin
        load_n = 1;
        rd_n   = 0;
      end
    end else if (m_load) begin
      load_n = 0;
      lw_n   = (3 * int'(conf_inshape[7:0])) / 4;
      kk     = int'(conf_kshape[1:0]);
      if (lw_n == 0 || kk == 0) begin
        err_n = 1;
      end else begin
        wl_n = lw_n;
        ll_n = kk;
      end
    end else if (m_wl > 0) begin
      if (!fifo_afull) begin
        rd_n = m_rd + 1;
        wl_n = m_wl - 1;
        if (wl_n == 0) end_n = 1;
      end
    end else if (m_end) begin
      end_n = 0;
      ll_n  = m_ll - 1;
      if (ll_n == 0) done_n = 1;
      else wl_n = m_lw;
    end else begin
      done_n = 0;
      err_n  = 0;
    end
    if (rst) model_valid <= 1'b1;
    m_lw <= lw_n; m_wl <= wl_n; m_ll <= ll_n; m_rd <= rd_n;
    m_load <= load_n; m_end <= end_n; m_done <= done_n; m_err <= err_n;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("req",   req,      (m_wl > 0) && !abort);
      chk("end",   line_end, m_end && !abort);
      chk("done",  done,     m_done && !abort);
      chk("err",   err,      m_err && !abort);
      chk("busy",  busy,     m_load || (m_wl > 0) || m_end || m_done || m_err);
      chk("stall", stall,    fifo_afull);
      chk("rdcnt", rd_cnt,   m_rd % 1024);
    end
  end

  // Per-cycle history of one directed scenario, cycle 0 = start cycle.
  logic [31:0] h_req, h_end, h_done, h_err, h_busy, h_stall;
  int          h_rd[32];

  task automatic set_idle();
    rst = 0; start = 0; abort = 0; fifo_afull = 0;
  endtask

  task automatic run_seq(input int w, input int k, input int n,
                         input int afl_lo, input int afl_hi, input int abort_c,
                         input int start2_c, input int rst_c);
    h_req = '0; h_end = '0; h_done = '0; h_err = '0; h_busy = '0; h_stall = '0;
    for (int c = 0; c < n; c++) begin
      conf_inshape = 32'h5A00_0000 | 32'(w);
      conf_kshape  = 32'hC3C3_C3C0 | 32'(k);
      start        = (c == 0) || (c == start2_c);
      abort        = (c == abort_c);
      fifo_afull   = (c >= afl_lo) && (c <= afl_hi);
      rst          = (c == rst_c);
      @(negedge clk);
      h_req[c]   = req;
      h_end[c]   = line_end;
      h_done[c]  = done;
      h_err[c]   = err;
      h_busy[c]  = busy;
      h_stall[c] = stall;
      h_rd[c]    = int'(rd_cnt);
      step();
    end
    set_idle();
    repeat (3) step();
  endtask

  initial begin
    int w;
    rst = 1; start = 0; abort = 0; fifo_afull = 0;
    conf_inshape = '0; conf_kshape = '0;
    repeat (3) step();
    rst = 0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_req",  req,  0);
    chk("reset_rd",   rd_cnt, 0);
    step();

    // W=8 -> 6 words per line, three lines
    run_seq(8, 3, 26, -1, -1, -1, -1, -1);
    chk("k3_req",  h_req, mask(2, 7) | mask(9, 14) | mask(16, 21));
    chk("k3_end",  h_end, mask(8, 8) | mask(15, 15) | mask(22, 22));
    chk("k3_done", h_done, mask(23, 23));
    chk("k3_err",  h_err, 0);
    chk("k3_rd",   h_rd[23], 18);

    run_seq(8, 1, 16, 4, 6, -1, -1, -1);
    chk("stall_req",   h_req, mask(2, 10));
    chk("stall_pin",   h_stall, mask(4, 6));
    chk("stall_end",   h_end, mask(11, 11));
    chk("stall_done",  h_done, mask(12, 12));
    chk("stall_rd",    h_rd[12], 6);

    run_seq(1, 3, 6, -1, -1, -1, -1, -1);
    chk("cfgerr_err",  h_err, mask(2, 2));
    chk("cfgerr_req",  h_req, 0);
    chk("cfgerr_busy", h_busy, mask(1, 2));

    run_seq(16, 2, 10, -1, -1, 5, -1, -1);
    chk("abort_busy", h_busy, mask(1, 5));
    chk("abort_rd",   h_rd[6], 3);
    chk("abort_end",  h_end, 0);
    chk("abort_done", h_done, 0);

    run_seq(8, 1, 14, -1, -1, -1, 4, -1);
    chk("restart_done", h_done, mask(9, 9));
    chk("restart_busy", h_busy, mask(1, 9));

    run_seq(8, 3, 14, -1, -1, -1, -1, 10);
    chk("midrst_busy10", h_busy[10], 1);
    chk("midrst_outs11", {h_req[11], h_end[11], h_done[11], h_err[11], h_busy[11]}, 0);
    chk("midrst_rd11",   h_rd[11], 0);
    run_seq(8, 3, 26, -1, -1, -1, -1, -1);
    chk("afterrst_done", h_done, mask(23, 23));
    chk("afterrst_rd",   h_rd[23], 18);

    // Randomized traffic, including config changes mid-pass.
    for (int c = 0; c < 6000; c++) begin
      rst        = ($urandom_range(0, 999) == 0);
      abort      = ($urandom_range(0, 255) == 0);
      start      = ($urandom_range(0, 3) == 0);
      fifo_afull = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 7))
          0:       w = $urandom_range(0, 3);
          7:       w = 255;
          default: w = $urandom_range(2, 20);
        endcase
        conf_inshape = {$urandom_range(0, 32'h00FF_FFFF) * 256} | 32'(w);
        conf_kshape  = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
      end
      step();
    end
    set_idle();
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
